led_sched: RTL and testbench
============================

LED_SCHED -- requirements
Module: led_sched

Interface
REQ-001 Parameter CLK_HZ, default 200_000_000, is the sys_clk frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1000, is the timebase tick rate; DIV = CLK_HZ/TICK_HZ cycles per tick, and DIV SHALL be >= 2.
REQ-003 Parameter ON_T, default 200, is the LED-on phase length in ticks.
REQ-004 Parameter OFF_T, default 200, is the LED-off phase length in ticks.
REQ-005 Parameter GAP_T, default 1000, is the post-sequence quiet gap in ticks.
REQ-006 Parameters ON_T, OFF_T and GAP_T SHALL each be >= 1.
REQ-007 sys_clk  in  1  single clock for all logic.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 req  in  4  per-requester level request; bit i belongs to requester i.
REQ-010 cnt  in  16  blink counts; cnt[4i+3:4i] belongs to requester i, range 0..15.
REQ-011 led  out  1  shared LED drive; 1 = on.
REQ-012 ack  out  4  one-cycle completion pulse to the served requester.
REQ-013 busy  out  1  high while any sequence is in service.
REQ-014 owner  out  2  index of the current or last served requester.

Function
REQ-015 States SHALL be IDLE, ON, OFF and GAP, and all outputs SHALL be registered.
REQ-016 In IDLE with any req bit high, the block SHALL grant round-robin, searching upward (with wrap) from owner+1.
REQ-017 At grant, the block SHALL latch the granted requester's cnt nibble and set owner.
REQ-018 A grant with a nonzero latched count SHALL enter ON in the next cycle, with led=1 and busy=1 in that cycle.
REQ-019 A grant with a zero latched count SHALL assert ack for exactly one cycle in the next cycle, keep led=0, and stay in IDLE.
REQ-020 Each phase SHALL last exactly phase_ticks*DIV cycles.
REQ-021 The cycle counter and tick counter SHALL clear on every phase entry, with no free-running tick alignment.
REQ-022 ON SHALL transition to OFF, and OFF SHALL transition to ON while remaining blinks are greater than 0, otherwise to GAP.
REQ-023 The remaining-blink count SHALL decrement on each ON-to-OFF transition and SHALL never wrap below 0.
REQ-024 led SHALL be 1 only in ON.
REQ-025 ack[owner] SHALL be high during the final cycle of GAP only, and the state SHALL be IDLE in the next cycle.
REQ-026 busy SHALL be high in ON, OFF and GAP, and low in IDLE.
REQ-027 A req deassert during service SHALL be ignored; the sequence SHALL complete and ack SHALL still pulse.
REQ-028 cnt changes after grant SHALL have no effect on the sequence in service.
REQ-029 A requester still holding req after its ack SHALL be re-arbitrated under round-robin, so other pending requesters win first.
REQ-030 At most one ack bit SHALL be high in any cycle.
REQ-031 Counter widths SHALL be sized from the parameters with $clog2, and no counter SHALL overflow at the maximum parameter values.

Reset
REQ-032 With rst high at a clock edge, the block SHALL set state=IDLE, led=0, ack=0, busy=0, owner=3, and clear all counters.
REQ-033 Resetting owner to 3 SHALL make requester 0 the first granted after reset.
REQ-034 Reset SHALL abort any sequence in progress with no ack issued.
REQ-035 A req held through reset SHALL be arbitrated in the first cycle after rst deasserts.

Structure
REQ-036 Package led_sched_pkg SHALL hold the state enum, NREQ=4 and CW=4 (count width).
REQ-037 Sub-module led_tick_timer SHALL count DIV cycles per tick and ticks up to a loaded limit.
REQ-038 led_tick_timer SHALL provide a synchronous clear input and a one-cycle done output.
REQ-039 The arbiter and FSM SHALL reside in led_sched.

Verification (CLK_HZ=10, TICK_HZ=1, ON_T=2, OFF_T=2, GAP_T=3, so DIV=10)
REQ-040 Single sequence: req=0001, cnt0=2 -> led high 20, low 20, high 20, low 20, then low 30; ack[0] in cycle 110 after the first ON cycle.
REQ-041 Round-robin: req=1111 out of reset with all counts 1 -> owner sequence 0,1,2,3 and exactly four ack pulses in order.
REQ-042 Zero count: req=0100, cnt2=0 -> ack[2] in the cycle after grant, led never high, busy never high.
REQ-043 Reset mid-ON: rst pulsed in cycle 5 of ON -> next cycle led=0, busy=0, ack=0; a held req[0] is regranted afterwards.
REQ-044 Starvation check: req[2] held continuously with req[1] raised during req[2]'s service -> requester 1 is granted before requester 2 again.
REQ-045 Maximum count: cnt=15 -> exactly 15 ON pulses, then GAP, then ack, with no counter wrap.

Source files
------------

// File: rtl/led_sched_pkg.sv
// led_sched_pkg -- shared types and helpers for the LED blink scheduler.
//   NREQ     : number of requesters sharing the LED
//   CW       : width of a per-requester blink count
//   OW       : width of a requester index
//   state_e  : scheduler states (IDLE / ON / OFF / GAP)
//   rr_pick  : round-robin pick starting one above the last owner
//   sat_dec  : decrement that holds at zero
package led_sched_pkg;

   localparam int NREQ = 4;
   localparam int CW   = 4;
   localparam int OW   = $clog2(NREQ);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2,
      ST_GAP  = 2'd3
   } state_e;

   // Search upward from last+1, wrapping; the last owner is checked last.
   function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [OW-1:0]   last);
      logic [OW-1:0] idx;
      logic [OW-1:0] pick;
      logic          found;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = last + OW'(k);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
      return (v == '0) ? '0 : v - CW'(1);
   endfunction

endpackage

// File: rtl/led_sched_if.sv
// led_sched_if -- request/status bundle between requesters and the scheduler.
//   req   : per-requester level request
//   cnt   : packed blink counts, CW bits per requester
//   led   : shared LED drive
//   ack   : one-cycle completion pulse to the served requester
//   busy  : a sequence is in service
//   owner : current or last served requester
// master = requester side, slave = scheduler side.
interface led_sched_if;
   import led_sched_pkg::*;

   logic [NREQ-1:0]    req;
   logic [NREQ*CW-1:0] cnt;
   logic               led;
   logic [NREQ-1:0]    ack;
   logic               busy;
   logic [OW-1:0]      owner;

   modport master (output req, cnt, input led, ack, busy, owner);
   modport slave  (input req, cnt, output led, ack, busy, owner);

endinterface

// File: rtl/led_tick_timer.sv
// led_tick_timer -- phase timer: DIV clock cycles per tick, ticks up to a
// limit loaded on clear.
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear; also loads lim for the new phase
//   lim      : phase length in ticks (>= 1)
//   done     : high in the last cycle of the phase (combinational pulse)
//   pre_done : high in the cycle before the last one (needs DIV >= 2)
module led_tick_timer #(
   parameter int DIV = 2,
   parameter int TW  = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [TW-1:0] lim,
   output logic          done,
   output logic          pre_done
);

   localparam int CYW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CYW-1:0] CYC_LAST = CYW'(DIV - 1);
   localparam logic [CYW-1:0] CYC_PRE  = CYW'(DIV - 2);

   logic [CYW-1:0] cyc_q, cyc_d;
   logic [TW-1:0]  tick_q, tick_d;
   logic [TW-1:0]  lim_q, lim_d;
   logic           tick_last;

   always_comb begin
      tick_last = (tick_q == lim_q - TW'(1));
      cyc_d     = cyc_q;
      tick_d    = tick_q;
      lim_d     = lim_q;
      if (clr) begin
         cyc_d  = '0;
         tick_d = '0;
         lim_d  = lim;
      end else if (cyc_q == CYC_LAST) begin
         cyc_d  = '0;
         tick_d = tick_last ? '0 : tick_q + TW'(1);
      end else begin
         cyc_d = cyc_q + CYW'(1);
      end
      done     = tick_last && (cyc_q == CYC_LAST);
      pre_done = tick_last && (cyc_q == CYC_PRE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q  <= '0;
         tick_q <= '0;
         lim_q  <= '0;
      end else begin
         cyc_q  <= cyc_d;
         tick_q <= tick_d;
         lim_q  <= lim_d;
      end
   end

endmodule

// File: rtl/led_sched.sv
// led_sched -- round-robin scheduler that lets one of NREQ requesters blink a
// shared LED cnt times (ON/OFF pairs), followed by a quiet GAP, then acks.
//   sys_clk : single clock
//   rst     : synchronous active-high reset
//   bus     : led_sched_if.slave (req, cnt in; led, ack, busy, owner out)
// All outputs are registered; they are computed from the next state.
module led_sched
   import led_sched_pkg::*;
#(
   parameter int CLK_HZ  = 200_000_000,
   parameter int TICK_HZ = 1000,
   parameter int ON_T    = 200,
   parameter int OFF_T   = 200,
   parameter int GAP_T   = 1000
) (
   input logic        sys_clk,
   input logic        rst,
   led_sched_if.slave bus
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int MAXT0 = (ON_T > OFF_T) ? ON_T : OFF_T;
   localparam int MAXT  = (MAXT0 > GAP_T) ? MAXT0 : GAP_T;
   localparam int TW    = $clog2(MAXT + 1);

   state_e          state_q, state_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   rem_q, rem_d;
   logic            led_q, led_d;
   logic            busy_q, busy_d;
   logic [NREQ-1:0] ack_q, ack_d;

   logic            grant_vld;
   logic [OW-1:0]   grant_idx;
   logic [CW-1:0]   grant_cnt;

   logic            tmr_clr;
   logic [TW-1:0]   tmr_lim;
   logic            tmr_done;
   logic            tmr_pre;

   led_tick_timer #(
      .DIV (DIV),
      .TW  (TW)
   ) u_timer (
      .clk      (sys_clk),
      .rst      (rst),
      .clr      (tmr_clr),
      .lim      (tmr_lim),
      .done     (tmr_done),
      .pre_done (tmr_pre)
   );

   // Arbiter: only active while idle.
   always_comb begin
      grant_vld = (state_q == ST_IDLE) && (|bus.req);
      grant_idx = rr_pick(bus.req, owner_q);
      grant_cnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == OW'(i)) grant_cnt = bus.cnt[i*CW +: CW];
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // rem_q was already decremented on ON->OFF, so OFF checks what is left.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (grant_vld && grant_cnt != '0) state_d = ST_ON;
         ST_ON:   if (tmr_done) state_d = ST_OFF;
         ST_OFF:  if (tmr_done) state_d = (rem_q != '0) ? ST_ON : ST_GAP;
         ST_GAP:  if (tmr_done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      owner_d = owner_q;
      rem_d   = rem_q;
      ack_d   = '0;
      if (grant_vld) begin
         owner_d = grant_idx;
         rem_d   = grant_cnt;
         // Zero-count request completes immediately without touching the LED.
         if (grant_cnt == '0) ack_d[grant_idx] = 1'b1;
      end
      if (state_q == ST_ON && tmr_done) rem_d = sat_dec(rem_q);
      // ack is registered, so it is raised one cycle early to land on the
      // final GAP cycle.
      if (state_q == ST_GAP && tmr_pre) ack_d[owner_q] = 1'b1;
      led_d  = (state_d == ST_ON);
      busy_d = (state_d != ST_IDLE);
      // Every phase entry restarts the timer from zero; idle keeps it parked.
      tmr_clr = (state_d != state_q) || (state_q == ST_IDLE);
      unique case (state_d)
         ST_ON:   tmr_lim = TW'(ON_T);
         ST_OFF:  tmr_lim = TW'(OFF_T);
         ST_GAP:  tmr_lim = TW'(GAP_T);
         default: tmr_lim = TW'(1);
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         owner_q <= OW'(NREQ - 1);
         rem_q   <= '0;
         ack_q   <= '0;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         owner_q <= owner_d;
         rem_q   <= rem_d;
         ack_q   <= ack_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.led   = led_q;
   assign bus.ack   = ack_q;
   assign bus.busy  = busy_q;
   assign bus.owner = owner_q;

endmodule

// File: tb/tb_led_sched.sv
// tb_led_sched -- scoreboard bench for led_sched.
// A transaction-level model decides each grant from the round-robin rule and
// the service length formula, pushing the expected completion into a queue;
// a monitor pops it on every ack and checks timing, owner, blink count,
// pulse widths and busy length.
module tb_led_sched;
   import led_sched_pkg::*;

   localparam int CLK_HZ = 10;
   localparam int TICK_HZ = 1;
   localparam int ON_T = 2;
   localparam int OFF_T = 2;
   localparam int GAP_T = 3;
   localparam int DIV = CLK_HZ / TICK_HZ;

   typedef struct {
      int     idx;
      int     n;
      longint ack_edge;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   led_sched_if bus();

   led_sched #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ),
      .ON_T    (ON_T),
      .OFF_T   (OFF_T),
      .GAP_T   (GAP_T)
   ) dut (
      .sys_clk (clk),
      .rst     (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int     errors = 0;
   int     checks = 0;
   exp_t   sb[$];
   longint e_cnt = 0;
   longint rst_edge = -1;
   longint free_edge = 0;
   int     m_owner = 3;
   int     m_pick;
   int     m_i;
   int     m_n;
   exp_t   m_e;

   function automatic int svc_len(input int n);
      return n * (ON_T + OFF_T) * DIV + GAP_T * DIV;
   endfunction

   // Reference model: evaluated on the active edge using the inputs the DUT sees.
   always @(posedge clk) begin
      e_cnt++;
      if (rst) begin
         sb.delete();
         m_owner   = 3;
         free_edge = e_cnt + 1;
         rst_edge  = e_cnt;
      end else if (e_cnt >= free_edge && bus.req != '0) begin
         m_pick = -1;
         for (int k = 1; k <= NREQ; k++) begin
            m_i = (m_owner + k) % NREQ;
            if (m_pick < 0 && bus.req[m_i]) m_pick = m_i;
         end
         m_n = int'(bus.cnt[m_pick*CW +: CW]);
         m_e.idx = m_pick;
         m_e.n   = m_n;
         if (m_n == 0) begin
            m_e.ack_edge = e_cnt;
            free_edge    = e_cnt + 1;
         end else begin
            m_e.ack_edge = e_cnt + svc_len(m_n) - 1;
            free_edge    = e_cnt + svc_len(m_n) + 1;
         end
         m_owner = m_pick;
         sb.push_back(m_e);
      end
   end

   // Monitor: samples on the falling edge.
   int   led_hi = 0;
   int   rises = 0;
   int   busy_hi = 0;
   int   run = 0;
   logic prev_led = 1'b0;
   exp_t got;
   int   exp_busy;

   always @(negedge clk) begin
      if (e_cnt == rst_edge) begin
         checks++;
         if (bus.led !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 4'b0 || bus.owner !== 2'd3) begin
            errors++;
            $display("FAIL reset_state: led=%b busy=%b ack=%b owner=%0d, want 0 0 0000 3",
                     bus.led, bus.busy, bus.ack, bus.owner);
         end
         led_hi = 0; rises = 0; busy_hi = 0; run = 0; prev_led = 1'b0;
      end else begin
         if (bus.led === 1'b1) begin
            led_hi++;
            run++;
            if (!prev_led) rises++;
         end else if (prev_led) begin
            checks++;
            if (run != ON_T * DIV) begin
               errors++;
               $display("FAIL on_width: got %0d cycles, want %0d", run, ON_T * DIV);
            end
            run = 0;
         end
         if (bus.busy === 1'b1) busy_hi++;
         prev_led = bus.led;
         if (bus.ack !== 4'b0) begin
            checks++;
            if (!$onehot(bus.ack)) begin
               errors++;
               $display("FAIL ack_onehot: ack=%b", bus.ack);
            end
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_ack: ack=%b at edge %0d, none expected", bus.ack, e_cnt);
            end else begin
               got = sb.pop_front();
               exp_busy = (got.n == 0) ? 0 : svc_len(got.n);
               checks++;
               if (bus.ack !== 4'(1 << got.idx)) begin
                  errors++;
                  $display("FAIL ack_idx: got %b, want %b", bus.ack, 4'(1 << got.idx));
               end
               checks++;
               if (e_cnt != got.ack_edge) begin
                  errors++;
                  $display("FAIL ack_time: got edge %0d, want %0d", e_cnt, got.ack_edge);
               end
               checks++;
               if (int'(bus.owner) != got.idx) begin
                  errors++;
                  $display("FAIL owner: got %0d, want %0d", bus.owner, got.idx);
               end
               checks++;
               if (rises != got.n) begin
                  errors++;
                  $display("FAIL blink_count: got %0d, want %0d", rises, got.n);
               end
               checks++;
               if (led_hi != got.n * ON_T * DIV) begin
                  errors++;
                  $display("FAIL led_on_cycles: got %0d, want %0d", led_hi, got.n * ON_T * DIV);
               end
               checks++;
               if (busy_hi != exp_busy) begin
                  errors++;
                  $display("FAIL busy_cycles: got %0d, want %0d", busy_hi, exp_busy);
               end
            end
            led_hi = 0; rises = 0; busy_hi = 0;
         end
      end
   end

   task automatic wait_acks(input int n, input int budget, input string tag);
      int seen = 0;
      int t = 0;
      while (seen < n && t < budget) begin
         @(negedge clk);
         t++;
         if (bus.ack !== 4'b0) seen++;
      end
      checks++;
      if (seen < n) begin
         errors++;
         $display("FAIL %s_timeout: got %0d acks, want %0d within %0d cycles", tag, seen, n, budget);
      end
   endtask

   task automatic wait_led(input int budget);
      int t = 0;
      while (bus.led !== 1'b1 && t < budget) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (bus.led !== 1'b1) begin
         errors++;
         $display("FAIL led_timeout: led=%b after %0d cycles, want 1", bus.led, budget);
      end
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   logic [15:0] rc;

   initial begin
      rst = 1'b1;
      bus.req = '0;
      bus.cnt = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Single sequence, requester 0 blinks twice.
      bus.req = 4'b0001;
      bus.cnt = 16'h0002;
      wait_acks(1, 300, "single");
      bus.req = '0;
      repeat (5) @(negedge clk);

      // Round-robin from reset: 0,1,2,3.
      do_reset(2);
      bus.req = 4'b1111;
      bus.cnt = 16'h1111;
      wait_acks(4, 400, "rr");
      bus.req = '0;
      repeat (5) @(negedge clk);

      // Zero count on requester 2.
      bus.req = 4'b0100;
      bus.cnt = 16'h0000;
      wait_acks(1, 20, "zero");
      bus.req = '0;
      repeat (5) @(negedge clk);

      // Reset during the fifth ON cycle with req[0] held.
      bus.req = 4'b0001;
      bus.cnt = 16'h0003;
      wait_led(20);
      repeat (4) @(negedge clk);
      do_reset(1);
      wait_acks(1, 300, "regrant");
      bus.req = '0;
      repeat (5) @(negedge clk);

      // req[2] held, req[1] raised mid-service: 1 must win before 2 again.
      bus.req = 4'b0100;
      bus.cnt = 16'h0110;
      wait_led(20);
      bus.req = 4'b0110;
      wait_acks(3, 400, "starve");
      bus.req = '0;
      repeat (5) @(negedge clk);

      // Maximum count.
      bus.req = 4'b1000;
      bus.cnt = 16'hF000;
      wait_acks(1, 800, "max");
      bus.req = '0;
      repeat (5) @(negedge clk);

      // Random traffic: requests drop and counts change mid-service.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 19) == 0) bus.req = 4'($urandom);
         if ($urandom_range(0, 29) == 0) begin
            for (int j = 0; j < NREQ; j++) rc[j*CW +: CW] = 4'($urandom_range(0, 3));
            bus.cnt = rc;
         end
         @(negedge clk);
      end
      bus.req = '0;
      repeat (700) @(negedge clk);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected acks never seen, want 0", sb.size());
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_busy: busy=%b, want 0", bus.busy);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
